reg_scoreboard: RTL and testbench

Register-dependency scoreboard for the 32×32 register file in the 5-stage pipeline. It sits beside the decode stage and tracks in-flight writes per architectural register. It stalls any instruction whose source operands or destination are not yet safe to use, and releases them as writeback retires writes. It also provides a drain handshake, so that control logic can quiesce the pipeline before touching register-file state.

---
 rtl/reg_scoreboard.sv | 116 +++++++++++
 tb/tb_reg_scoreboard.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard with decode stall and drain handshake
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_read1,
    input  logic [4:0] i_id_read2,
    input  logic       i_id_use1,
    input  logic       i_id_use2,
    input  logic       i_id_regWrite,
    input  logic [4:0] i_id_writeReg,
    input  logic       i_wb_regWrite,
    input  logic [4:0] i_wb_writeReg,
    input  logic       i_drain_req,
    output logic       o_id_stall,
    output logic       o_busy,
    output logic [6:0] o_inflight,
    output logic       o_drain_ack,
    output logic       o_err
);
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t           r_state;
    logic             r_ack;
    logic             r_busy;
    logic [6:0]       r_inflight;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt [1:31];

    logic [CNT_W-1:0] w_cur [32];
    logic [CNT_W-1:0] w_dec [32];
    logic [CNT_W-1:0] w_nxt [32];
    logic [6:0]       w_sum;
    logic             w_zero;
    logic             w_raw;
    logic             w_ovf;
    logic             w_block;
    logic             w_issue;
    logic             w_err_ev;

    // Effective counts (writeback retiring this cycle already visible), hazards and next-state counters
    always_comb begin
        w_cur[0] = '0;
        w_dec[0] = '0;
        w_nxt[0] = '0;
        for (int r = 1; r < 32; r++) begin
            w_cur[r] = r_cnt[r];
            w_dec[r] = r_cnt[r] - CNT_W'(i_wb_regWrite && i_wb_writeReg == 5'(r) && r_cnt[r] != '0);
        end
        w_raw    = (i_id_use1 && w_dec[i_id_read1] != '0) || (i_id_use2 && w_dec[i_id_read2] != '0);
        w_ovf    = i_id_regWrite && i_id_writeReg != '0 && w_dec[i_id_writeReg] == MAX;
        w_block  = i_drain_req || r_state != IDLE;
        o_id_stall = i_id_valid && (w_raw || w_ovf || w_block);
        w_issue  = i_id_valid && !o_id_stall;
        w_err_ev = i_wb_regWrite && i_wb_writeReg != '0 && w_cur[i_wb_writeReg] == '0;
        w_sum    = '0;
        for (int r = 1; r < 32; r++) begin
            w_nxt[r] = w_dec[r] + CNT_W'(w_issue && i_id_regWrite && i_id_writeReg == 5'(r));
            w_sum    = w_sum + 7'(w_nxt[r]);
        end
        w_zero = w_sum == '0;
    end

    // Pending counters and their registered summaries, plus the sticky underflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
            r_busy     <= 1'b0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) r_cnt[r] <= w_nxt[r];
            r_busy     <= !w_zero;
            r_inflight <= w_sum;
            r_err      <= r_err || w_err_ev;
        end
    end

    // Drain handshake: ack once the post-update counters are all zero, drop a cycle after the request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_drain_req) begin
                    r_state <= w_zero ? DONE : DRAIN;
                    r_ack   <= w_zero;
                end
                DRAIN: if (!i_drain_req) begin
                    r_state <= IDLE;
                end else if (w_zero) begin
                    r_state <= DONE;
                    r_ack   <= 1'b1;
                end
                DONE: if (!i_drain_req) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_inflight  = r_inflight;
    assign o_drain_ack = r_ack;
    assign o_err       = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed plus randomized checks against an array-based scoreboard model
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0, u1 = 1'b0, u2 = 1'b0, rw = 1'b0, wbw = 1'b0, dq = 1'b0;
    logic [4:0] r1 = '0, r2 = '0, wd = '0, wbr = '0;
    logic       stall, busy, ack, err;
    logic [6:0] inflight;

    int n_chk = 0;
    int n_pass = 0;
    int m_cnt [32];
    bit m_err;
    int m_phase;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_valid(v), .i_id_read1(r1), .i_id_read2(r2),
        .i_id_use1(u1), .i_id_use2(u2),
        .i_id_regWrite(rw), .i_id_writeReg(wd),
        .i_wb_regWrite(wbw), .i_wb_writeReg(wbr),
        .i_drain_req(dq),
        .o_id_stall(stall), .o_busy(busy), .o_inflight(inflight),
        .o_drain_ack(ack), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int eff(input int r);
        if (r == 0) return 0;
        if (wbw && int'(wbr) == r && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0;
        m_phase = 0;
    endtask

    // inputs are already applied; check stall now, then the registered outputs after the edge
    task automatic step();
        bit raw, ovf, exp_stall, issue;
        int nxt [32];
        int sum;
        #1;
        raw = (u1 && eff(r1) != 0) || (u2 && eff(r2) != 0);
        ovf = rw && wd != 0 && eff(wd) == 3;
        exp_stall = v && (raw || ovf || dq || m_phase != 0);
        chk("id_stall", stall, exp_stall);
        issue = v && !exp_stall;
        sum = 0;
        for (int r = 0; r < 32; r++) begin
            nxt[r] = eff(r) + ((issue && rw && r != 0 && int'(wd) == r) ? 1 : 0);
            sum += nxt[r];
        end
        if (wbw && wbr != 0 && m_cnt[wbr] == 0) m_err = 1;
        m_phase = !dq ? 0 : (m_phase == 2 || sum == 0) ? 2 : 1;
        m_cnt = nxt;
        @(posedge clk);
        #1;
        chk("busy", busy, sum != 0);
        chk("inflight", inflight, sum);
        chk("err", err, m_err);
        chk("drain_ack", ack, m_phase == 2);
    endtask

    task automatic put(input bit iv, input int ir1, input bit iu1, input int ir2, input bit iu2,
                       input bit irw, input int iwd, input bit iwbw, input int iwbr, input bit idq);
        @(negedge clk);
        v = iv; r1 = 5'(ir1); u1 = iu1; r2 = 5'(ir2); u2 = iu2;
        rw = irw; wd = 5'(iwd); wbw = iwbw; wbr = 5'(iwbr); dq = idq;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        {v, u1, u2, rw, wbw, dq} = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        chk("por_busy", busy, 0);
        chk("por_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        put(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("add3_inflight", inflight, 1);
        put(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        put(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
        chk("wb3_inflight", inflight, 0);

        put(1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        put(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_inflight", inflight, 0);

        repeat (3) put(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("r5_three", inflight, 3);
        put(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        put(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        chk("r5_swap", inflight, 3);
        repeat (3) put(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

        put(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        put(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        chk("r7_busy", busy, 1);
        put(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        put(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        chk("err_set", err, 1);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        put(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        put(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        put(1, 0, 0, 0, 0, 1, 12, 0, 0, 1);
        put(0, 0, 0, 0, 0, 0, 0, 1, 10, 1);
        put(0, 0, 0, 0, 0, 0, 0, 1, 11, 1);
        chk("drain_ack_up", ack, 1);
        put(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        put(1, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        chk("drain_ack_down", ack, 0);
        put(1, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        chk("resume", inflight, 1);
        put(1, 0, 0, 0, 0, 1, 12, 0, 0, 1);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) do_reset();
            @(negedge clk);
            v = 1'($urandom); r1 = 5'($urandom_range(0, 7)); u1 = 1'($urandom);
            r2 = 5'($urandom_range(0, 7)); u2 = 1'($urandom);
            rw = 1'($urandom); wd = 5'($urandom_range(0, 7));
            wbw = 1'($urandom); wbr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dq = ~dq;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
